// File: rtl/mul_pkg.sv
// Shared types and constants for the radix-4 Booth multiplier that hands
// a carry-save pair plus the top partial product to a downstream adder.
package mul_pkg;

    localparam int OPW         = 32;
    localparam int RESW        = 64;
    localparam int NDIG        = 16;
    localparam int CALC_CYCLES = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bitwise majority, i.e. the carry output of a full adder.
    function automatic logic [RESW-1:0] maj3(input logic [RESW-1:0] a,
                                             input logic [RESW-1:0] b,
                                             input logic [RESW-1:0] c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// Radix-4 Booth recode of one 3-bit multiplier window and generation of
// the matching 64-bit two's-complement partial product, already shifted.
module booth_pp_gen
    import mul_pkg::*;
(
    input  logic [OPW-1:0]  mcand,
    input  logic [2:0]      win,
    input  logic [3:0]      idx,
    output logic [RESW-1:0] pp
);

    logic [RESW-1:0] mc_ext_s;
    logic [RESW-1:0] mag_s;
    logic [RESW-1:0] val_s;
    logic            neg_s;

    // Recode window to {0,+-1,+-2} x mcand, negate, then weight by 4^idx.
    always_comb begin
        mc_ext_s = {{(RESW-OPW){mcand[OPW-1]}}, mcand};
        mag_s    = {RESW{1'b0}};
        neg_s    = 1'b0;
        case (win)
            3'b001, 3'b010: mag_s = mc_ext_s;
            3'b101, 3'b110: begin
                mag_s = mc_ext_s;
                neg_s = 1'b1;
            end
            3'b011:         mag_s = mc_ext_s << 1;
            3'b100: begin
                mag_s = mc_ext_s << 1;
                neg_s = 1'b1;
            end
            default:        mag_s = {RESW{1'b0}};
        endcase
        if (neg_s) begin
            val_s = ~mag_s + 64'd1;
        end else begin
            val_s = mag_s;
        end
        pp = val_s << {idx, 1'b0};
    end

endmodule

// File: rtl/mul_booth_acc.sv
// Sequential radix-4 Booth multiplier: folds PP_0..PP_14 into a carry-save
// pair one digit per cycle, then presents {S, C, PP_15} for a 3-input add.
module mul_booth_acc
    import mul_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OPW-1:0]  mcand,
    input  logic [OPW-1:0]  mplier,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [RESW-1:0] op1,
    output logic [RESW-1:0] op2,
    output logic [RESW-1:0] op3
);

    localparam logic [3:0] K_LAST  = 4'(CALC_CYCLES - 1);
    localparam logic [3:0] TOP_IDX = 4'(NDIG - 1);

    state_t          state_r, state_nx_s;
    logic [3:0]      k_r;
    logic [RESW-1:0] s_r, c_r;
    logic [OPW-1:0]  mcand_r, mplier_r;
    logic [RESW-1:0] op1_r, op2_r, op3_r;
    logic            out_valid_r, in_ready_r;

    logic [OPW:0]    mplier_ext_s;
    logic [2:0]      win_k_s, win_top_s;
    logic [RESW-1:0] pp_k_s, pp_top_s;
    logic [RESW-1:0] s_nx_s, c_nx_s;

    // Appending the implicit bit -1 = 0 makes window i start at bit 2i.
    assign mplier_ext_s = {mplier_r, 1'b0};
    assign win_k_s      = mplier_ext_s[{1'b0, k_r, 1'b0} +: 3];
    assign win_top_s    = mplier_ext_s[OPW -: 3];

    booth_pp_gen u_pp_k (
        .mcand (mcand_r),
        .win   (win_k_s),
        .idx   (k_r),
        .pp    (pp_k_s)
    );

    booth_pp_gen u_pp_top (
        .mcand (mcand_r),
        .win   (win_top_s),
        .idx   (TOP_IDX),
        .pp    (pp_top_s)
    );

    assign s_nx_s = s_r ^ c_r ^ pp_k_s;
    assign c_nx_s = maj3(s_r, c_r, pp_k_s) << 1;

    // Next-state decode; in_ready_r mirrors state==IDLE one-for-one.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid && in_ready_r) begin
                    state_nx_s = CALC;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            CALC: begin
                if (k_r == K_LAST) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = CALC;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = DONE;
                end
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // Datapath and registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            k_r         <= 4'd0;
            s_r         <= {RESW{1'b0}};
            c_r         <= {RESW{1'b0}};
            mcand_r     <= {OPW{1'b0}};
            mplier_r    <= {OPW{1'b0}};
            op1_r       <= {RESW{1'b0}};
            op2_r       <= {RESW{1'b0}};
            op3_r       <= {RESW{1'b0}};
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            state_r    <= state_nx_s;
            in_ready_r <= (state_nx_s == IDLE);
            case (state_r)
                IDLE: begin
                    if (in_valid && in_ready_r) begin
                        mcand_r  <= mcand;
                        mplier_r <= mplier;
                        s_r      <= {RESW{1'b0}};
                        c_r      <= {RESW{1'b0}};
                        k_r      <= 4'd0;
                    end
                end
                CALC: begin
                    s_r <= s_nx_s;
                    c_r <= c_nx_s;
                    k_r <= k_r + 4'd1;
                    // Last fold: publish the compressed pair straight from the adder tree.
                    if (k_r == K_LAST) begin
                        op1_r       <= s_nx_s;
                        op2_r       <= c_nx_s;
                        op3_r       <= pp_top_s;
                        out_valid_r <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        op1_r       <= {RESW{1'b0}};
                        op2_r       <= {RESW{1'b0}};
                        op3_r       <= {RESW{1'b0}};
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    op1_r       <= {RESW{1'b0}};
                    op2_r       <= {RESW{1'b0}};
                    op3_r       <= {RESW{1'b0}};
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign op1       = op1_r;
    assign op2       = op2_r;
    assign op3       = op3_r;

endmodule

// File: tb/tb_mul_booth_acc.sv
// Self-checking bench for mul_booth_acc: directed corners, backpressure,
// mid-operation reset and a randomized back-to-back stream vs. plain arithmetic.
module tb_mul_booth_acc;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] op1, op2, op3;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    mul_booth_acc dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mcand     (mcand),
        .mplier    (mplier),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .op1       (op1),
        .op2       (op2),
        .op3       (op3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: exact signed product, wrapped to 64 bits.
    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return p;
    endfunction

    // Reference: top Booth digit = -2*b31 + b30 + b29, weighted by 4^15.
    function automatic logic [63:0] ref_pp15(input logic [31:0] a, input logic [31:0] b);
        int     d;
        longint v;
        d = -2 * int'(b[31]) + int'(b[30]) + int'(b[29]);
        v = longint'(d) * longint'($signed(a));
        return v << 30;
    endfunction

    // Present operands and wait (bounded) for the accepting edge; scramble after.
    task automatic do_accept(input logic [31:0] a, input logic [31:0] b,
                             input bit hold, output bit ok, output int acc_cyc);
        ok = 1'b0;
        acc_cyc = 0;
        @(negedge clk);
        mcand    = a;
        mplier   = b;
        in_valid = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (in_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
                acc_cyc = cyc;
                break;
            end
            @(negedge clk);
        end
        if (!hold) in_valid = 1'b0;
        mcand  = $urandom;
        mplier = $urandom;
    endtask

    // Count sampling points after acceptance until out_valid is seen high.
    task automatic wait_valid(output int cycles, output bit ok);
        ok = 1'b0;
        cycles = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (out_valid) begin
                cycles = c;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            $display("FAIL reset_hs: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end else passed++;
        total++;
        if ({op1, op2, op3} !== {192{1'b0}}) begin
            $display("FAIL reset_ops: op1=%h op2=%h op3=%h want 0", op1, op2, op3);
        end else passed++;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin
            $display("FAIL reset_release: in_ready=%b want 1", in_ready);
        end else passed++;
    endtask

    task automatic test_directed;
        logic [31:0] ta [5];
        logic [31:0] tb [5];
        logic [63:0] te [5];
        logic [63:0] sum;
        bit ok;
        int cycles, acc;
        ta[0] = 32'd3;          tb[0] = 32'd5;          te[0] = 64'd15;
        ta[1] = 32'hFFFF_FFFF;  tb[1] = 32'd1;          te[1] = 64'hFFFF_FFFF_FFFF_FFFF;
        ta[2] = 32'h8000_0000;  tb[2] = 32'h8000_0000;  te[2] = 64'h4000_0000_0000_0000;
        ta[3] = 32'h8000_0000;  tb[3] = 32'h7FFF_FFFF;  te[3] = 64'hC000_0000_8000_0000;
        ta[4] = 32'h8000_0000;  tb[4] = 32'h0000_0004;  te[4] = 64'hFFFF_FFFE_0000_0000;
        for (int i = 0; i < 5; i++) begin
            do_accept(ta[i], tb[i], 1'b0, ok, acc);
            total++;
            if (!ok) $display("FAIL dir_accept[%0d]: accepted=%b want 1", i, ok);
            else passed++;
            wait_valid(cycles, ok);
            total++;
            if (!ok || cycles != 16) begin
                $display("FAIL dir_latency[%0d]: got %0d cycles (seen=%b) want 16", i, cycles, ok);
            end else passed++;
            sum = op1 + op2 + op3;
            total++;
            if (sum !== te[i]) begin
                $display("FAIL dir_sum[%0d]: got %h want %h", i, sum, te[i]);
            end else passed++;
            total++;
            if (op3 !== ref_pp15(ta[i], tb[i])) begin
                $display("FAIL dir_pp15[%0d]: got %h want %h", i, op3, ref_pp15(ta[i], tb[i]));
            end else passed++;
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
        end
    endtask

    task automatic test_backpressure;
        logic [63:0] s1, s2, s3;
        logic [31:0] a, b;
        bit ok, stable;
        int cycles, acc;
        // out_ready while idle must be harmless.
        out_ready = 1'b1;
        stable = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || op1 !== 64'd0) stable = 1'b0;
        end
        out_ready = 1'b0;
        total++;
        if (!stable) $display("FAIL idle_out_ready: idle outputs disturbed (out_valid=%b in_ready=%b)", out_valid, in_ready);
        else passed++;

        a = $urandom;
        b = $urandom;
        do_accept(a, b, 1'b0, ok, acc);
        wait_valid(cycles, ok);
        total++;
        if (!ok) $display("FAIL bp_valid: out_valid never seen, want 1");
        else passed++;
        s1 = op1; s2 = op2; s3 = op3;
        total++;
        if (s1 + s2 + s3 !== ref_prod(a, b)) begin
            $display("FAIL bp_sum: got %h want %h", s1 + s2 + s3, ref_prod(a, b));
        end else passed++;
        stable = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || op1 !== s1 || op2 !== s2 || op3 !== s3)
                stable = 1'b0;
        end
        total++;
        if (!stable) $display("FAIL bp_hold: outputs changed while stalled (out_valid=%b in_ready=%b)", out_valid, in_ready);
        else passed++;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || {op1, op2, op3} !== {192{1'b0}}) begin
            $display("FAIL bp_release: in_ready=%b out_valid=%b op1=%h want 1/0/0", in_ready, out_valid, op1);
        end else passed++;
    endtask

    task automatic test_reset_mid_calc;
        logic [63:0] sum;
        bit ok, seen;
        int cycles, acc;
        do_accept(32'd123456, 32'd654321, 1'b0, ok, acc);
        repeat (7) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || {op1, op2, op3} !== {192{1'b0}}) begin
            $display("FAIL rst_async: in_ready=%b out_valid=%b op1=%h want 1/0/0", in_ready, out_valid, op1);
        end else passed++;
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        out_ready = 1'b0;
        total++;
        if (seen) $display("FAIL rst_abort: out_valid=1 after abort, want 0");
        else passed++;
        do_accept(32'd7, 32'hFFFF_FFF7, 1'b0, ok, acc);
        wait_valid(cycles, ok);
        total++;
        if (!ok || cycles != 16) $display("FAIL rst_next_latency: got %0d want 16", cycles);
        else passed++;
        sum = op1 + op2 + op3;
        total++;
        if (sum !== 64'hFFFF_FFFF_FFFF_FFC1) $display("FAIL rst_next_sum: got %h want %h", sum, 64'hFFFF_FFFF_FFFF_FFC1);
        else passed++;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [31:0] a, b;
        logic [63:0] sum;
        bit ok;
        int cycles, acc, prev_acc;
        int bad_sum, bad_gap, bad_to;
        bad_sum = 0; bad_gap = 0; bad_to = 0;
        prev_acc = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            a = $urandom;
            b = $urandom;
            if (i % 40 == 1) a = 32'h8000_0000;
            if (i % 40 == 2) b = 32'h8000_0000;
            do_accept(a, b, 1'b1, ok, acc);
            if (!ok) bad_to++;
            if (i > 0 && acc - prev_acc < 17) begin
                bad_gap++;
                total++;
                $display("FAIL b2b_gap[%0d]: accept gap %0d want >=17", i, acc - prev_acc);
            end
            prev_acc = acc;
            wait_valid(cycles, ok);
            sum = op1 + op2 + op3;
            total++;
            if (!ok || sum !== ref_prod(a, b)) begin
                bad_sum++;
                $display("FAIL b2b_sum[%0d]: %h*%h got %h want %h", i, a, b, sum, ref_prod(a, b));
            end else passed++;
        end
        in_valid  = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        total++;
        if (bad_to != 0 || bad_gap != 0) begin
            $display("FAIL b2b_flow: timeouts=%0d short_gaps=%0d want 0/0", bad_to, bad_gap);
        end else passed++;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        mcand     = 32'd0;
        mplier    = 32'd0;
        test_reset;
        test_directed;
        test_backpressure;
        test_reset_mid_calc;
        test_back_to_back;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mul_booth_acc.md
MUL_BOOTH_ACC -- requirements
Module: mul_booth_acc

Interface
REQ-001 SHALL have no parameters; operand width is fixed at 32 bits signed and output width at 64 bits.
REQ-002 SHALL have one clock; reset is asynchronous and active-high.
REQ-003 SHALL provide `clk`  input  1  rising-edge clock.
REQ-004 SHALL provide `rst`  input  1  asynchronous active-high reset.
REQ-005 SHALL provide `in_valid`  input  1  operands present.
REQ-006 SHALL provide `in_ready`  output  1  block can accept operands.
REQ-007 SHALL provide `mcand`  input  32  signed multiplicand.
REQ-008 SHALL provide `mplier`  input  32  signed multiplier.
REQ-009 SHALL provide `out_valid`  output  1  operands for the downstream 3-operand 64-bit adder are valid.
REQ-010 SHALL provide `out_ready`  input  1  downstream accepts.
REQ-011 SHALL provide `op1`, `op2`, `op3`  output  64 each  carry-save sum, carry-save carry, final partial product.

Function
REQ-012 SHALL implement the FSM states IDLE, CALC and DONE.
REQ-013 IDLE SHALL go to CALC on `in_valid && in_ready`, latching `mcand`/`mplier`, clearing S=0 and C=0, and clearing the iteration counter k=0.
REQ-014 SHALL hold `in_ready` = (state==IDLE); input changes after acceptance SHALL be ignored.
REQ-015 SHALL form Booth radix-4 digit i (0..15) from mplier bits {2i+1, 2i, 2i-1}, with bit -1 = 0; the digit SHALL be in {-2,-1,0,+1,+2}.
REQ-016 SHALL form PP_i = (digit_i × sign-extended mcand) << 2i as a full 64-bit two's-complement value, with no hot-one or sign-encoding tricks.
REQ-017 Each CALC cycle with k in 0..14 SHALL perform a 3:2 compression: S' = S^C^PP_k, C' = maj(S,C,PP_k)<<1 truncated to 64 bits, then k increments.
REQ-018 CALC SHALL last exactly 15 cycles; after the k=14 update the FSM SHALL go to DONE.
REQ-019 In DONE, `out_valid` SHALL be 1, `op1`=S, `op2`=C and `op3`=PP_15.
REQ-020 The relation (op1+op2+op3) mod 2^64 SHALL equal the signed product sign-extended to 64 bits.
REQ-021 `out_valid` SHALL first assert 16 cycles after the acceptance edge.
REQ-022 DONE SHALL hold `out_valid` and stable outputs until `out_ready`; on `out_valid && out_ready` the FSM SHALL go to IDLE.
REQ-023 No overlap is required: the next accept SHALL occur no earlier than the cycle after the output handshake.
REQ-024 Outside DONE, `op1`/`op2`/`op3` SHALL not be relied upon; they SHALL be driven 0 in IDLE.
REQ-025 Corner cases SHALL be exact: mcand=-2^31 with digit -2 (value 2^32), and mplier=-2^31 (top digit -2).
REQ-026 `out_ready` asserted outside DONE SHALL have no effect.

Reset
REQ-027 `rst` SHALL asynchronously force state=IDLE, k=0, S=C=0, latched operands=0, `out_valid`=0, `in_ready`=1 and `op1`/`op2`/`op3`=0.
REQ-028 Reset mid-CALC or in DONE SHALL abort the operation with no output handshake; the first accept after reset release SHALL behave as from power-up.

Structure
REQ-029 Shared package `mul_pkg` SHALL hold the state enum, OPW=32, RESW=64, NDIG=16 and CALC_CYCLES=15.
REQ-030 Digit recode plus PP_i generation SHALL be one combinational sub-module `booth_pp_gen` (inputs: mcand, 3-bit window, digit index; output: 64-bit PP).
REQ-031 The 3:2 compression SHALL be inline in `mul_booth_acc`.

Verification
REQ-032 Directed test: mcand=3, mplier=5 -> `out_valid` at cycle 16 after accept; op1+op2+op3 = 64'd15.
REQ-033 Directed test: mcand=-1, mplier=1 -> sum = 64'hFFFF_FFFF_FFFF_FFFF.
REQ-034 Directed test: mcand=mplier=32'h8000_0000 -> sum = 64'h4000_0000_0000_0000; mcand=32'h8000_0000, mplier=32'h7FFF_FFFF -> sum = 64'hC000_0000_8000_0000.
REQ-035 Directed test: `out_ready` low for 5 cycles in DONE -> `out_valid` and op1..op3 stable, `in_ready`=0 throughout; handshake then returns to IDLE.
REQ-036 Directed test: `rst` pulse at k=7 -> `out_valid` never rises for that operation; next op 7×(-9) -> sum = -63 sign-extended.
REQ-037 Directed test: `in_valid` held high with 200 random operand pairs -> every sum matches the reference product; one accept per 17+ cycles.
